// File: rtl/controlador_rtc.sv
// Bus controller between a PicoBlaze and an external RTC on a multiplexed
// Intel-style address/data bus. Each start runs one address phase and one data phase.
module controlador_rtc #(
    parameter int PHASE_CYCLES = 6
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] port_out00,
    input  logic [7:0] port_out01,
    input  logic [1:0] port_out02,
    output logic [7:0] port_in00,
    output logic       AD,
    output logic       CS,
    output logic       WR,
    output logic       RD,
    inout  wire  [7:0] salient
);

    localparam int CNT_W = (PHASE_CYCLES > 1) ? $clog2(PHASE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(PHASE_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        ADDR_ACT,
        ADDR_REC,
        DATA_ACT,
        DATA_REC
    } state_t;

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             start_sync, start_prev, start;
    logic [7:0]       addr_q, addr_n, data_q, data_n;
    logic             dir_q, dir_n;
    logic [7:0]       bus_q, bus_n;
    logic             bus_oe, bus_oe_n;
    logic             ad_n, cs_n, wr_n, rd_n;
    logic             capture;
    logic             last;

    assign start = start_sync & ~start_prev;
    assign last  = (cnt == LAST);

    // Outputs are decoded from the next state so the registered strobes line up with the state register.
    always_comb begin
        state_n  = state;
        cnt_n    = cnt + CNT_W'(1);
        addr_n   = addr_q;
        data_n   = data_q;
        dir_n    = dir_q;
        capture  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_n = ADDR_ACT;
                    addr_n  = port_out00;
                    data_n  = port_out01;
                    dir_n   = port_out02[1];
                end
            end
            ADDR_ACT: if (last) state_n = ADDR_REC;
            ADDR_REC: if (last) state_n = DATA_ACT;
            DATA_ACT: begin
                if (last) begin
                    state_n = DATA_REC;
                    capture = dir_q;
                end
            end
            DATA_REC: if (last) state_n = IDLE;
            default:  state_n = IDLE;
        endcase
        if (state_n != state || state == IDLE) cnt_n = '0;

        ad_n     = 1'b1;
        cs_n     = 1'b1;
        wr_n     = 1'b1;
        rd_n     = 1'b1;
        bus_oe_n = 1'b0;
        bus_n    = addr_n;
        case (state_n)
            ADDR_ACT: begin
                ad_n     = 1'b0;
                cs_n     = 1'b0;
                wr_n     = 1'b0;
                bus_oe_n = 1'b1;
            end
            DATA_ACT: begin
                cs_n = 1'b0;
                if (dir_n) begin
                    rd_n = 1'b0;
                end else begin
                    wr_n     = 1'b0;
                    bus_oe_n = 1'b1;
                    bus_n    = data_n;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            start_sync <= 1'b0;
            start_prev <= 1'b0;
            addr_q     <= 8'h00;
            data_q     <= 8'h00;
            dir_q      <= 1'b0;
            bus_q      <= 8'h00;
            bus_oe     <= 1'b0;
            AD         <= 1'b1;
            CS         <= 1'b1;
            WR         <= 1'b1;
            RD         <= 1'b1;
            port_in00  <= 8'h00;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            start_sync <= port_out02[0];
            start_prev <= start_sync;
            addr_q     <= addr_n;
            data_q     <= data_n;
            dir_q      <= dir_n;
            bus_q      <= bus_n;
            bus_oe     <= bus_oe_n;
            AD         <= ad_n;
            CS         <= cs_n;
            WR         <= wr_n;
            RD         <= rd_n;
            if (capture) port_in00 <= salient;
        end
    end

    assign salient = bus_oe ? bus_q : 8'hzz;

endmodule

// File: tb/tb_controlador_rtc.sv
// Scoreboard bench for controlador_rtc: expected per-cycle bus activity is queued
// when a command is issued and compared cycle by cycle against the pins.
module tb_controlador_rtc;

    localparam int P = 6;

    typedef struct packed {
        logic       ad;
        logic       cs;
        logic       wr;
        logic       rd;
        logic [7:0] bus;
        logic [7:0] pin;
    } obs_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] port_out00 = 8'h00;
    logic [7:0] port_out01 = 8'h00;
    logic [1:0] port_out02 = 2'b00;
    logic [7:0] port_in00;
    logic       AD, CS, WR, RD;
    wire  [7:0] salient;
    logic       rtc_en = 1'b0;
    logic [7:0] rtc_data = 8'h00;

    int   tests_run = 0;
    int   tests_failed = 0;
    obs_t exp_q[$];
    obs_t got, want;

    controlador_rtc #(.PHASE_CYCLES(P)) dut (
        .clk(clk), .reset(reset),
        .port_out00(port_out00), .port_out01(port_out01), .port_out02(port_out02),
        .port_in00(port_in00),
        .AD(AD), .CS(CS), .WR(WR), .RD(RD),
        .salient(salient)
    );

    // The RTC only answers while its read strobe is low.
    assign salient = (rtc_en && !RD) ? rtc_data : 8'hzz;

    always #5 clk = ~clk;

    function automatic obs_t mk(input logic [3:0] strobes, input logic [7:0] bus, input logic [7:0] pin);
        obs_t r;
        {r.ad, r.cs, r.wr, r.rd} = strobes;
        r.bus = bus;
        r.pin = pin;
        return r;
    endfunction

    function automatic void push_bus_cycle(input logic [7:0] addr, input logic [7:0] data,
                                           input logic dir, input logic [7:0] rtc_val,
                                           input logic [7:0] pin_before, input int tail_idle);
        logic [7:0] pin_after;
        pin_after = dir ? rtc_val : pin_before;
        exp_q.push_back(mk(4'b1111, 8'hzz, pin_before));
        for (int i = 0; i < P; i++) exp_q.push_back(mk(4'b0001, addr, pin_before));
        for (int i = 0; i < P; i++) exp_q.push_back(mk(4'b1111, 8'hzz, pin_before));
        for (int i = 0; i < P; i++)
            exp_q.push_back(dir ? mk(4'b1010, rtc_val, pin_before) : mk(4'b1001, data, pin_before));
        for (int i = 0; i < P; i++) exp_q.push_back(mk(4'b1111, 8'hzz, pin_after));
        for (int i = 0; i < tail_idle; i++) exp_q.push_back(mk(4'b1111, 8'hzz, pin_after));
    endfunction

    task automatic sample();
        got = mk({AD, CS, WR, RD}, salient, port_in00);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        sample();
        tests_run++;
        if (got !== mk(4'b1111, 8'hzz, 8'h00)) begin
            tests_failed++;
            $display("[TB] FAIL reset_hold: got %h required %h", got, mk(4'b1111, 8'hzz, 8'h00));
        end
        reset = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        sample();
        tests_run++;
        if (got !== mk(4'b1111, 8'hzz, 8'h00)) begin
            tests_failed++;
            $display("[TB] FAIL reset_release_idle: got %h required %h", got, mk(4'b1111, 8'hzz, 8'h00));
        end
    endtask

    task automatic test_write();
        port_out00 = 8'h12;
        port_out01 = 8'h23;
        port_out02 = 2'b01;
        push_bus_cycle(8'h12, 8'h23, 1'b0, 8'h00, 8'h00, 3);
        for (int c = 0; exp_q.size() > 0; c++) begin
            @(posedge clk);
            #1;
            sample();
            want = exp_q.pop_front();
            tests_run++;
            if (got !== want) begin
                tests_failed++;
                $display("[TB] FAIL write cyc %0d: got %h required %h", c, got, want);
            end
            if (c == 7) port_out02 = 2'b00;
        end
    endtask

    task automatic test_read();
        rtc_en     = 1'b1;
        rtc_data   = 8'h5A;
        port_out00 = 8'h12;
        port_out02 = 2'b11;
        push_bus_cycle(8'h12, 8'h23, 1'b1, 8'h5A, 8'h00, 3);
        for (int c = 0; exp_q.size() > 0; c++) begin
            @(posedge clk);
            #1;
            sample();
            want = exp_q.pop_front();
            tests_run++;
            if (got !== want) begin
                tests_failed++;
                $display("[TB] FAIL read cyc %0d: got %h required %h", c, got, want);
            end
            if (c == 1) port_out02 = 2'b10;
        end
        rtc_en = 1'b0;
    endtask

    task automatic test_start_held();
        port_out00 = 8'h34;
        port_out01 = 8'h56;
        port_out02 = 2'b01;
        push_bus_cycle(8'h34, 8'h56, 1'b0, 8'h00, 8'h5A, 80);
        for (int c = 0; exp_q.size() > 0; c++) begin
            @(posedge clk);
            #1;
            sample();
            want = exp_q.pop_front();
            tests_run++;
            if (got !== want) begin
                tests_failed++;
                $display("[TB] FAIL start_held cyc %0d: got %h required %h", c, got, want);
            end
            if (c == 99) port_out02 = 2'b00;
        end
    endtask

    task automatic test_busy_start();
        port_out00 = 8'h41;
        port_out01 = 8'h7E;
        port_out02 = 2'b01;
        push_bus_cycle(8'h41, 8'h7E, 1'b0, 8'h00, 8'h5A, 12);
        for (int c = 0; exp_q.size() > 0; c++) begin
            @(posedge clk);
            #1;
            sample();
            want = exp_q.pop_front();
            tests_run++;
            if (got !== want) begin
                tests_failed++;
                $display("[TB] FAIL busy_start cyc %0d: got %h required %h", c, got, want);
            end
            if (c == 4) port_out02 = 2'b00;
            if (c == 10) begin
                port_out00 = 8'hFF;
                port_out01 = 8'hEE;
                port_out02 = 2'b11;
            end
            if (c == 14) port_out02 = 2'b00;
        end
    endtask

    task automatic test_reset_mid_read();
        rtc_en     = 1'b1;
        rtc_data   = 8'hA5;
        port_out00 = 8'h09;
        port_out02 = 2'b11;
        push_bus_cycle(8'h09, 8'h7E, 1'b1, 8'hA5, 8'h5A, 0);
        for (int c = 0; c < 1 + 2 * P + 3; c++) begin
            @(posedge clk);
            #1;
            sample();
            want = exp_q.pop_front();
            tests_run++;
            if (got !== want) begin
                tests_failed++;
                $display("[TB] FAIL reset_mid_read cyc %0d: got %h required %h", c, got, want);
            end
            if (c == 1) port_out02 = 2'b10;
        end
        exp_q.delete();
        #2;
        reset = 1'b1;
        #1;
        sample();
        tests_run++;
        if (got !== mk(4'b1111, 8'hzz, 8'h00)) begin
            tests_failed++;
            $display("[TB] FAIL reset_abort: got %h required %h", got, mk(4'b1111, 8'hzz, 8'h00));
        end
        rtc_en     = 1'b0;
        port_out02 = 2'b00;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        port_out00 = 8'h07;
        port_out01 = 8'h99;
        port_out02 = 2'b01;
        push_bus_cycle(8'h07, 8'h99, 1'b0, 8'h00, 8'h00, 3);
        for (int c = 0; exp_q.size() > 0; c++) begin
            @(posedge clk);
            #1;
            sample();
            want = exp_q.pop_front();
            tests_run++;
            if (got !== want) begin
                tests_failed++;
                $display("[TB] FAIL post_reset_write cyc %0d: got %h required %h", c, got, want);
            end
            if (c == 3) port_out02 = 2'b00;
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_start_held();
        test_busy_start();
        test_reset_mid_read();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
